// File: rtl/VX_gpu_pkg.sv
// VX_gpu_pkg
// Shared constants and helpers for the dispatch arbiter slice.
//   ARB_SEL_W(n)  : width of a lane index for n lanes. It is never below 1,
//                   so a single-lane arbiter still has a 1-bit sel_out.
//   PERF_CTR_BITS : width of the optional stall counter. That counter exists
//                   only when DISPATCH_ARB_PERF_EN is defined.
package VX_gpu_pkg;

  localparam int PERF_CTR_BITS = 32;

  function automatic int ARB_SEL_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/VX_dispatch_arb_buf.sv
// VX_dispatch_arb_buf
// Small circular output FIFO for the dispatch arbiter. The full and empty
// flags are registered, so the arbiter's ready_in never sees a combinational
// path from the downstream ready.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   push       : write data_in (ignored when full)
//   data_in    : entry to store
//   pop        : consume the head entry (ignored when empty)
//   data_out   : head entry
//   empty      : registered "no entries" flag
//   full       : registered "DEPTH entries" flag
module VX_dispatch_arb_buf #(
  parameter int DATAW = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [DATAW-1:0] data_in,
  input  logic             pop,
  output logic [DATAW-1:0] data_out,
  output logic             empty,
  output logic             full
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [DATAW-1:0] mem [DEPTH];
  logic [PTRW-1:0]  rd_ptr;
  logic [PTRW-1:0]  wr_ptr;
  logic [CNTW-1:0]  count;
  logic [CNTW-1:0]  count_n;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap explicitly, so DEPTH does not have to be a power of two.
  function automatic logic [PTRW-1:0] next_ptr(input logic [PTRW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // Compute the occupancy for the next cycle. The flags are registered from
  // this value, so they are valid right after the edge.
  always_comb begin
    count_n = count;
    if (do_push && !do_pop) begin
      count_n = count + 1'b1;
    end else if (!do_push && do_pop) begin
      count_n = count - 1'b1;
    end
  end

  // Storage, pointers and flags. Reset also clears the storage, so the head
  // reads back as zero while the FIFO is empty after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      count <= count_n;
      empty <= (count_n == '0);
      full  <= (int'(count_n) == DEPTH);
    end
  end

  assign data_out = mem[rd_ptr];

endmodule

// File: rtl/vx_dispatch_arb.sv
// vx_dispatch_arb
// Shares one functional-unit dispatch port between NUM_INPUTS issue lanes.
// It uses round-robin arbitration with an optional burst lock of up to
// MAX_BURST consecutive grants per lane. A registered 2-entry output buffer
// isolates ready_out from ready_in.
// Optional feature: define DISPATCH_ARB_PERF_EN to add the perf_stalls port.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   valid_in    : per-lane request valid
//   data_in     : per-lane payload, lane i at [i*DATAW +: DATAW]
//   ready_in    : per-lane accept, one-hot or zero
//   valid_out   : output beat valid (buffer not empty)
//   data_out    : payload of the buffered head beat
//   sel_out     : lane index that produced data_out
//   ready_out   : downstream accept
//   perf_stalls : cycles with a pending request but no transfer (optional)
module vx_dispatch_arb
  import VX_gpu_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int DATAW      = 64,
  parameter int MAX_BURST  = 1,
  parameter int SELW       = ARB_SEL_W(NUM_INPUTS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_INPUTS-1:0]       valid_in,
  input  logic [NUM_INPUTS*DATAW-1:0] data_in,
  output logic [NUM_INPUTS-1:0]       ready_in,
  output logic                        valid_out,
  output logic [DATAW-1:0]            data_out,
  output logic [SELW-1:0]             sel_out,
  input  logic                        ready_out
`ifdef DISPATCH_ARB_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0]    perf_stalls
`endif
);

  localparam int CNTW = $clog2(MAX_BURST + 1);
  localparam int BUFW = DATAW + SELW;

  logic [SELW-1:0]       ptr;
  logic [SELW-1:0]       owner;
  logic                  locked;
  logic [CNTW-1:0]       burst_cnt;

  logic                  owner_valid;
  logic [NUM_INPUTS-1:0] rotated;
  logic                  rr_found;
  logic [SELW-1:0]       rr_off;
  logic [SELW-1:0]       rr_grant;
  logic                  has_grant;
  logic [SELW-1:0]       grant;
  logic [CNTW-1:0]       eff_cnt;
  logic                  xfer;

  logic                  buf_full;
  logic                  buf_empty;
  logic [BUFW-1:0]       buf_din;
  logic [BUFW-1:0]       buf_dout;

  // A lock only holds while its owner is still requesting. If the owner has
  // dropped, this cycle already falls back to round-robin. The burst count
  // then starts again from zero for whichever lane wins.
  assign owner_valid = locked && valid_in[owner];
  assign eff_cnt     = owner_valid ? burst_cnt : '0;

  // Rotate the request vector so that the lane at ptr becomes bit 0.
  always_comb begin
    rotated = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      rotated[k] = valid_in[(int'(ptr) + k) % NUM_INPUTS];
    end
  end

  // Find the first set bit in the rotated vector. The loop runs downwards,
  // so the lowest offset is the last one written and wins.
  always_comb begin
    rr_found = 1'b0;
    rr_off   = '0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        rr_found = 1'b1;
        rr_off   = SELW'(k);
      end
    end
  end

  assign rr_grant = SELW'((int'(ptr) + int'(rr_off)) % NUM_INPUTS);

  // The lock owner takes precedence. Otherwise the round-robin winner is
  // granted.
  always_comb begin
    has_grant = 1'b0;
    grant     = '0;
    if (owner_valid) begin
      has_grant = 1'b1;
      grant     = owner;
    end else if (rr_found) begin
      has_grant = 1'b1;
      grant     = rr_grant;
    end
  end

  // ready_in depends only on registered state and valid_in, never on
  // ready_out.
  always_comb begin
    ready_in = '0;
    if (has_grant && !buf_full && !reset) begin
      ready_in[grant] = 1'b1;
    end
  end

  assign xfer = |(valid_in & ready_in);

  // Arbitration state. A transfer either extends the current burst or ends
  // it and advances the round-robin pointer past the winner. When the buffer
  // is full, nothing changes.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      owner     <= '0;
      locked    <= 1'b0;
      burst_cnt <= '0;
    end else if (xfer) begin
      if (int'(eff_cnt) + 1 < MAX_BURST) begin
        locked    <= 1'b1;
        owner     <= grant;
        burst_cnt <= eff_cnt + 1'b1;
      end else begin
        locked    <= 1'b0;
        burst_cnt <= '0;
        ptr       <= SELW'((int'(grant) + 1) % NUM_INPUTS);
      end
    end else if (locked && !valid_in[owner] && !buf_full) begin
      locked    <= 1'b0;
      burst_cnt <= '0;
    end
  end

  assign buf_din = {grant, data_in[int'(grant)*DATAW +: DATAW]};

  VX_dispatch_arb_buf #(
    .DATAW (BUFW),
    .DEPTH (2)
  ) out_buf (
    .clk      (clk),
    .reset    (reset),
    .push     (xfer),
    .data_in  (buf_din),
    .pop      (ready_out),
    .data_out (buf_dout),
    .empty    (buf_empty),
    .full     (buf_full)
  );

  assign valid_out          = !buf_empty;
  assign {sel_out, data_out} = buf_dout;

`ifdef DISPATCH_ARB_PERF_EN
  // Count cycles where some lane was waiting but nothing was accepted. The
  // counter wraps naturally at its width.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stalls <= '0;
    end else if (|valid_in && !xfer) begin
      perf_stalls <= perf_stalls + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vx_dispatch_arb.sv
// tb_vx_dispatch_arb
// Bench for vx_dispatch_arb with two instances:
//   dut_a : 4 lanes, MAX_BURST=1 (pure round-robin, power-of-two lane count)
//   dut_b : 3 lanes, MAX_BURST=3 (burst lock, non-power-of-two wrap)
// It uses a vector table for round-robin and backpressure, hand-written
// burst, lock-release and mid-stream reset sequences, and randomized traffic
// against a queue-based reference model.
// Define DISPATCH_ARB_PERF_EN to also cover perf_stalls.
module tb_vx_dispatch_arb;
  import VX_gpu_pkg::*;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;

  logic [3:0]      valid_a, ready_in_a;
  logic [4*DW-1:0] data_a;
  logic            valid_out_a, ready_out_a;
  logic [DW-1:0]   data_out_a;
  logic [1:0]      sel_a;

  logic [2:0]      valid_b, ready_in_b;
  logic [3*DW-1:0] data_b;
  logic            valid_out_b, ready_out_b;
  logic [DW-1:0]   data_out_b;
  logic [1:0]      sel_b;

`ifdef DISPATCH_ARB_PERF_EN
  logic [PERF_CTR_BITS-1:0] perf_a, perf_b;
`endif

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [3:0] valid;
    logic       rdy;
    logic [3:0] exp_ready;
    logic       exp_vout;
    logic [1:0] exp_sel;
  } vec_t;

  vec_t vecs[14];
  int   burst_exp[7];
  int   rel_exp[5];

  always #5 clk = ~clk;

  vx_dispatch_arb #(.NUM_INPUTS(4), .DATAW(DW), .MAX_BURST(1)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_a),
    .data_in   (data_a),
    .ready_in  (ready_in_a),
    .valid_out (valid_out_a),
    .data_out  (data_out_a),
    .sel_out   (sel_a),
    .ready_out (ready_out_a)
`ifdef DISPATCH_ARB_PERF_EN
    ,
    .perf_stalls (perf_a)
`endif
  );

  vx_dispatch_arb #(.NUM_INPUTS(3), .DATAW(DW), .MAX_BURST(3)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_b),
    .data_in   (data_b),
    .ready_in  (ready_in_b),
    .valid_out (valid_out_b),
    .data_out  (data_out_b),
    .sel_out   (sel_b),
    .ready_out (ready_out_b)
`ifdef DISPATCH_ARB_PERF_EN
    ,
    .perf_stalls (perf_b)
`endif
  );

  // Watchdog so a stuck run still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic rdy);
    valid_a     = v;
    ready_out_a = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset       = 1'b1;
    valid_a     = '0;
    valid_b     = '0;
    ready_out_a = 1'b1;
    ready_out_b = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Randomized traffic against a reference model. Each lane holds a pending
  // beat until it is accepted. The model keeps the output buffer as a queue
  // and tracks which lane holds the current burst and how many beats it has
  // used.
  task automatic randomTest(input int which, input int n, input int mb, input int cycles);
    int               rr_start;
    int               burst_lane;
    int               burst_used;
    int               stalls;
    logic [DW+1:0]    q[$];
    logic             pend[4];
    logic [DW-1:0]    pdata[4];
    rr_start   = 0;
    burst_lane = -1;
    burst_used = 0;
    stalls     = 0;
    for (int l = 0; l < 4; l++) begin
      pend[l]  = 1'b0;
      pdata[l] = '0;
    end
    doReset();
    for (int c = 0; c < cycles; c++) begin
      int              g;
      int              used;
      logic            full;
      logic            rdy;
      logic            acc;
      logic            any;
      logic [3:0]      vv;
      logic [3:0]      exp_rdy;
      logic [3:0]      act_rdy;
      logic [4*DW-1:0] dd;
      logic            act_v;
      logic [1:0]      act_sel;
      logic [DW-1:0]   act_d;
      for (int l = 0; l < n; l++) begin
        if (!pend[l] && $urandom_range(0, 99) < 60) begin
          pend[l]  = 1'b1;
          pdata[l] = DW'($urandom);
        end
      end
      rdy = ($urandom_range(0, 99) < 70);
      vv  = '0;
      dd  = '0;
      any = 1'b0;
      for (int l = 0; l < n; l++) begin
        vv[l]           = pend[l];
        dd[l*DW +: DW]  = pdata[l];
        any             = any | pend[l];
      end
      if (which == 0) begin
        valid_a = vv; data_a = dd; ready_out_a = rdy;
      end else begin
        valid_b = vv[2:0]; data_b = dd[3*DW-1:0]; ready_out_b = rdy;
      end
      full = (q.size() == 2);
      g = -1;
      if (burst_lane >= 0 && pend[burst_lane]) begin
        g = burst_lane;
      end else begin
        for (int k = 0; k < n; k++) begin
          if (g < 0 && pend[(rr_start + k) % n]) g = (rr_start + k) % n;
        end
      end
      acc     = (g >= 0) && !full;
      exp_rdy = acc ? 4'(1 << g) : 4'b0000;
      @(negedge clk);
      if (which == 0) begin
        act_rdy = ready_in_a; act_v = valid_out_a; act_sel = sel_a; act_d = data_out_a;
      end else begin
        act_rdy = {1'b0, ready_in_b}; act_v = valid_out_b; act_sel = sel_b; act_d = data_out_b;
      end
      checkOutput("rand_ready", 64'(act_rdy), 64'(exp_rdy));
      checkOutput("rand_vout", 64'(act_v), 64'(q.size() > 0));
      if (q.size() > 0) begin
        checkOutput("rand_sel", 64'(act_sel), 64'(q[0][DW+1:DW]));
        checkOutput("rand_data", 64'(act_d), 64'(q[0][DW-1:0]));
      end
`ifdef DISPATCH_ARB_PERF_EN
      checkOutput("rand_perf", (which == 0) ? 64'(perf_a) : 64'(perf_b), 64'(stalls));
`endif
      @(posedge clk);
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (any && !acc) stalls++;
      if (acc) begin
        q.push_back({2'(g), pdata[g]});
        pend[g] = 1'b0;
        used = ((burst_lane == g) ? burst_used : 0) + 1;
        if (used < mb) begin
          burst_lane = g;
          burst_used = used;
        end else begin
          burst_lane = -1;
          burst_used = 0;
          rr_start   = (g + 1) % n;
        end
      end else if (!full && burst_lane >= 0 && !pend[burst_lane]) begin
        burst_lane = -1;
        burst_used = 0;
      end
      #1;
    end
  endtask

  initial begin
    int k;
    int acc0;

    vecs[0]  = '{4'hF, 1'b1, 4'b0001, 1'b0, 2'd0};
    vecs[1]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd0};
    vecs[2]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd1};
    vecs[3]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd2};
    vecs[4]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd3};
    vecs[5]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd0};
    vecs[6]  = '{4'hF, 1'b0, 4'b0100, 1'b1, 2'd1};
    vecs[7]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 2'd1};
    vecs[8]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 2'd1};
    vecs[9]  = '{4'hF, 1'b1, 4'b0000, 1'b1, 2'd1};
    vecs[10] = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd2};
    vecs[11] = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd3};
    vecs[12] = '{4'h0, 1'b1, 4'b0000, 1'b1, 2'd0};
    vecs[13] = '{4'h0, 1'b1, 4'b0000, 1'b0, 2'd0};
    burst_exp = '{1, 1, 1, 2, 2, 2, 1};
    rel_exp   = '{0, 0, 2, 2, 2};

    // Reset state, with requests already present during reset.
    reset       = 1'b1;
    valid_a     = 4'hF;
    valid_b     = 3'b111;
    ready_out_a = 1'b1;
    ready_out_b = 1'b1;
    data_a      = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    data_b      = {16'hB002, 16'hB001, 16'hB000};
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", 64'(ready_in_a), 64'h0);
    checkOutput("rst_vout", 64'(valid_out_a), 64'h0);
    checkOutput("rst_sel", 64'(sel_a), 64'h0);
    checkOutput("rst_data", 64'(data_out_a), 64'h0);
    checkOutput("rst_ready_b", 64'(ready_in_b), 64'h0);
    tick();
    doReset();

    // Round-robin and backpressure table on dut_a.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].rdy);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_ready", i), 64'(ready_in_a), 64'(vecs[i].exp_ready));
      checkOutput($sformatf("vec%0d_vout", i), 64'(valid_out_a), 64'(vecs[i].exp_vout));
      if (vecs[i].exp_vout) begin
        checkOutput($sformatf("vec%0d_sel", i), 64'(sel_a), 64'(vecs[i].exp_sel));
        checkOutput($sformatf("vec%0d_data", i), 64'(data_out_a), 64'(16'hA000 + vecs[i].exp_sel));
      end
      tick();
    end

    // Burst lock on dut_b: lanes 1 and 2 always requesting.
    doReset();
    valid_b = 3'b110;
    k = 0;
    for (int c = 0; c < 20 && k < 7; c++) begin
      @(negedge clk);
      if (valid_out_b) begin
        checkOutput($sformatf("burst_sel%0d", k), 64'(sel_b), 64'(burst_exp[k]));
        k++;
      end
      tick();
    end
    if (k < 7) checkOutput("burst_timeout", 64'(k), 64'd7);

    // Lock release: lane 0 sends two beats then stops, lane 2 keeps asking.
    doReset();
    valid_b = 3'b101;
    k = 0;
    acc0 = 0;
    for (int c = 0; c < 20 && k < 5; c++) begin
      @(negedge clk);
      if (valid_out_b) begin
        checkOutput($sformatf("release_sel%0d", k), 64'(sel_b), 64'(rel_exp[k]));
        k++;
      end
      if (ready_in_b[0]) acc0++;
      tick();
      if (acc0 == 2) valid_b[0] = 1'b0;
    end
    if (k < 5) checkOutput("release_timeout", 64'(k), 64'd5);

    // Reset while the buffer is full and lane 1 holds a lock.
    doReset();
    valid_b     = 3'b010;
    ready_out_b = 1'b0;
    tick();
    tick();
    valid_b = 3'b011;
    reset   = 1'b1;
    @(negedge clk);
    checkOutput("midrst_ready_in_reset", 64'(ready_in_b), 64'h0);
    checkOutput("midrst_vout_before", 64'(valid_out_b), 64'h1);
    tick();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_vout_after", 64'(valid_out_b), 64'h0);
    checkOutput("midrst_ready_lane0", 64'(ready_in_b), 64'h1);
    tick();
    ready_out_b = 1'b1;
    @(negedge clk);
    checkOutput("midrst_first_vout", 64'(valid_out_b), 64'h1);
    checkOutput("midrst_first_sel", 64'(sel_b), 64'h0);
    tick();

`ifdef DISPATCH_ARB_PERF_EN
    // Two accepted beats fill the buffer, then five stalled cycles follow.
    doReset();
    @(negedge clk);
    checkOutput("perf_reset", 64'(perf_a), 64'h0);
    tick();
    applyStimulus(4'hF, 1'b0);
    for (int c = 0; c < 7; c++) tick();
    @(negedge clk);
    checkOutput("perf_stalls", 64'(perf_a), 64'd5);
    tick();
`endif

    randomTest(0, 4, 1, 400);
    randomTest(1, 3, 3, 400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
